lsu: RTL and testbench
======================

# lsu

Load/store unit for the single-cycle RISC-V core; sits directly downstream of the ALU and consumes its 32-bit result as the effective address for `lw/lh/lb/lhu/lbu/sw/sh/sb`. It generates byte-lane enables and aligned word addresses toward data memory, waits on a request/acknowledge handshake, and returns sign- or zero-extended load data for write-back. While an access is outstanding it holds `busy` high so the core stalls its PC. It also reports misaligned, illegal and timed-out accesses.

## Interface
- `TIMEOUT`, 16: maximum number of REQ cycles waited for `dmem_ack` before aborting; legal range 2..255.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request strobe from control, sampled only in IDLE.
- `mem_read` in 1: access is a load.
- `mem_write` in 1: access is a store.
- `funct3` in 3: RISC-V width/sign field (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in 32: effective address (ALU result).
- `wdata` in 32: store data (rs2).
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse ending every accepted access.
- `rdata` out 32: extended load data, valid from the `done` cycle and held until the next successful load.
- `err` out 1: pulses with `done` when the access faulted.
- `err_code` out 2: 00 none, 01 misaligned, 10 illegal, 11 timeout; valid with `done`, otherwise 00.
- `dmem_req` out 1: memory request, registered.
- `dmem_we` out 1: write enable qualifying `dmem_req`.
- `dmem_addr` out 32: `{addr[31:2],2'b00}`, registered at accept.
- `dmem_be` out 4: byte enables (stores); 1111 for loads.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rdata` in 32: memory read word, valid when `dmem_ack`=1.
- `dmem_ack` in 1: memory completion, sampled only in REQ.

## Operation
- States are IDLE, REQ and RESP.
- **Accept:** in IDLE, `start`=1 with exactly one of `mem_read`/`mem_write` latches `addr`, `funct3`, `wdata` and the direction.
- **Illegal:** the access is illegal when both `mem_read` and `mem_write` are 1, or when `funct3` is not listed for the direction (loads allow 000/001/010/100/101; stores allow 000/001/010).
- **Misaligned:** halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Illegal takes priority over misaligned.
- **Faulted access:** IDLE→RESP directly. No `dmem_req` is issued, `rdata` is unchanged, and `err`=1 with the corresponding code.
- **Legal access:** IDLE→REQ.
- `start`=1 with both `mem_read` and `mem_write` at 0 is ignored and the FSM stays in IDLE.
- **REQ:** `dmem_req`=1, and `dmem_we`/`dmem_addr`/`dmem_be`/`dmem_wdata` are held stable. On `dmem_ack`=1 go to RESP; a load captures the extended data into `rdata` on that edge.
- **Timeout:** a cycle counter clears on entry to REQ. If the TIMEOUT-th REQ cycle passes without ack, go to RESP with `err_code`=11. An ack in that same cycle wins and the access completes normally.
- **RESP:** `done`=1 for one cycle, then go to IDLE. `start` is not sampled in RESP.
- **Store lanes:** `sb` uses `be`=0001<<addr[1:0] with `wdata[7:0]` replicated ×4. `sh` uses `be`=0011 or 1100 (by `addr[1]`) with `wdata[15:0]` replicated ×2. `sw` uses `be`=1111 and `wdata` as is.
- **Load lanes:** the byte is selected by `addr[1:0]` and the halfword by `addr[1]`. `lb`/`lh` sign-extend; `lbu`/`lhu` zero-extend.
- **Reset values:** all outputs are 0 and the state is IDLE. Reset has priority in every state; a reset during REQ drops `dmem_req` at the next edge with no `done`.

## Timing
- Cycle 0: IDLE with `start`. Cycle 1: REQ, `dmem_req`=1, `busy`=1.
- Ack at REQ cycle n (n≥1): `done`/`rdata` valid at cycle n+1. The minimum access latency is 2 cycles with `busy` high for 2 cycles.
- Faulted access: `done`/`err` at cycle 1, `busy` high for 1 cycle, and `dmem_req` stays 0 throughout.
- Timeout: `dmem_req` is high for exactly TIMEOUT cycles, and `done` follows in the next cycle.
- The next `start` is accepted in the cycle after RESP at the earliest.
- `dmem_ack` outside REQ is ignored.

## Test plan
- **`lb` sign-extension:** `lb`, `addr`=0x0000_0103, ack at REQ cycle 1 with `dmem_rdata`=0x80FF_1234 → `dmem_addr`=0x100, `be`=1111, `done` at cycle 2, `rdata`=0xFFFF_FF80.
- **`lhu`, late ack:** `lhu`, `addr`=0x202, `dmem_rdata`=0xBEEF_0001, ack after 3 REQ cycles → `rdata`=0x0000_BEEF, `busy` high for 4 cycles.
- **`sb` lanes:** `sb`, `addr`=0x11, `wdata`=0x1234_56AB → `dmem_we`=1, `be`=0010, `dmem_wdata`=0xABAB_ABAB, `dmem_addr`=0x10, `rdata` unchanged.
- **Faults:** `sw` to 0x102 → `err_code`=01 at cycle 1, no `dmem_req`. `mem_read`=`mem_write`=1 at a misaligned address → `err_code`=10.
- **Timeout boundary:** `TIMEOUT`=16 with no ack → `dmem_req` high for 16 cycles, then `done` with `err_code`=11. Ack exactly on REQ cycle 16 → normal completion, `err`=0.
- **Reset mid-access:** `rst_n`=0 during REQ cycle 2 → IDLE next edge, `dmem_req`=0, `rdata`=0, no `done`. A `start` issued immediately after reset is accepted normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address into one data-memory word access.
// Latency: 2 cycles minimum (REQ then RESP); faulted accesses finish in 1 cycle.
// Backpressure: waits in REQ for dmem_ack, up to TIMEOUT cycles; busy stalls the core.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   start, mem_read, mem_write,
//   funct3, addr, wdata             access request from the core (sampled in IDLE)
//   busy, done, rdata, err,
//   err_code                        status / load result back to the core
//   dmem_req, dmem_we, dmem_addr,
//   dmem_be, dmem_wdata             request toward data memory (held through REQ)
//   dmem_rdata, dmem_ack            completion from data memory
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  cnt_q, cnt_d;

  // Request decode on the raw inputs, only meaningful in IDLE.
  logic        illegal, misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  // Load extraction on the returning memory word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    illegal = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end else if (mem_read) begin
      illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                  funct3 == 3'b100 || funct3 == 3'b101);
    end else if (mem_write) begin
      illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    end

    // funct3[1:0] encodes the width for both signed and unsigned variants.
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    st_be    = 4'b1111;
    st_wdata = wdata;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << addr[1:0];
          st_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          st_be    = addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{wdata[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = 8'(dmem_rdata >> {lane_q, 3'b000});
    ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    rdata_d      = rdata_q;
    err_code_d   = err_code_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        err_code_d = ERR_NONE;
        // start with neither direction set is not an access at all.
        if (start && (mem_read || mem_write)) begin
          we_d     = mem_write;
          funct3_d = funct3;
          lane_d   = addr[1:0];
          if (illegal) begin
            err_code_d = ERR_ILL;
            state_d    = S_RESP;
          end else if (misaligned) begin
            err_code_d = ERR_MIS;
            state_d    = S_RESP;
          end else begin
            dmem_addr_d  = {addr[31:2], 2'b00};
            dmem_be_d    = st_be;
            dmem_wdata_d = st_wdata;
            cnt_d        = 8'd0;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        // cnt_q holds (REQ cycle number - 1); an ack on the last cycle still wins.
        if (dmem_ack) begin
          state_d = S_RESP;
          if (!we_q) begin
            rdata_d = ld_ext;
          end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_code_d = ERR_TMO;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      dmem_addr_q  <= 32'd0;
      dmem_be_q    <= 4'd0;
      dmem_wdata_q <= 32'd0;
      rdata_q      <= 32'd0;
      err_code_q   <= ERR_NONE;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      rdata_q      <= rdata_d;
      err_code_q   <= err_code_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_RESP);
  assign err_code   = done ? err_code_q : ERR_NONE;
  assign err        = done && (err_code_q != ERR_NONE);
  assign rdata      = rdata_q;
  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = dmem_req && we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int n_checks = 0;
  int n_err    = 0;
  int reqs;
  int busy_cnt;

  lsu #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .err_code   (err_code),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge; inputs changed here
  // are seen at the following edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    start     = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    tick();
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'd0;
    addr       = 32'd0;
    wdata      = 32'd0;
    dmem_rdata = 32'd0;
    dmem_ack   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_req",    {31'd0, dmem_req}, 32'd0);
    chk("rst_rdata",  rdata, 32'd0);
    chk("rst_outs",   {dmem_addr ^ dmem_wdata, dmem_be, dmem_we, err, err_code}, 32'd0);
    rst_n = 1'b1;
    tick();

    // lb, addr 0x103, ack on REQ cycle 1
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0);
    chk("lb_req",   {31'd0, dmem_req}, 32'd1);
    chk("lb_busy",  {31'd0, busy}, 32'd1);
    chk("lb_addr",  dmem_addr, 32'h0000_0100);
    chk("lb_be",    {28'd0, dmem_be}, 32'hF);
    chk("lb_we",    {31'd0, dmem_we}, 32'd0);
    dmem_rdata = 32'h80FF_1234;
    dmem_ack   = 1'b1;
    tick();
    dmem_ack   = 1'b0;
    chk("lb_done",  {31'd0, done}, 32'd1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_err",   {29'd0, err, err_code}, 32'd0);
    tick();
    chk("lb_idle",  {31'd0, busy}, 32'd0);

    // lhu, addr 0x202, ack on REQ cycle 3 -> busy for 4 cycles
    busy_cnt = 0;
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'd0);
    dmem_rdata = 32'hBEEF_0001;
    for (int i = 0; i < 10 && !done; i++) begin
      if (busy) busy_cnt++;
      dmem_ack = (i == 2);
      tick();
    end
    dmem_ack = 1'b0;
    if (busy) busy_cnt++;
    chk("lhu_done",  {31'd0, done}, 32'd1);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);
    chk("lhu_busy",  busy_cnt, 32'd4);
    tick();

    // Ignored start: neither direction
    issue(1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
    chk("nop_busy", {31'd0, busy}, 32'd0);

    // sb, addr 0x11
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h1234_56AB);
    chk("sb_we",    {31'd0, dmem_we}, 32'd1);
    chk("sb_be",    {28'd0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr",  dmem_addr, 32'h0000_0010);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sb_done",  {31'd0, done}, 32'd1);
    chk("sb_rdata", rdata, 32'h0000_BEEF);
    tick();

    // sh, addr 0x22 -> upper lanes
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'hAAAA_5678);
    chk("sh_be",    {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h5678_5678);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();

    // sw misaligned
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'hDEAD_BEEF);
    chk("mis_done", {31'd0, done}, 32'd1);
    chk("mis_code", {30'd0, err_code}, 32'd1);
    chk("mis_err",  {31'd0, err}, 32'd1);
    chk("mis_req",  {31'd0, dmem_req}, 32'd0);
    tick();
    chk("mis_idle", {30'd0, busy, err_code}, 32'd0);

    // read+write together at a misaligned address: illegal wins
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0103, 32'd0);
    chk("ill_code", {30'd0, err_code}, 32'd2);
    chk("ill_req",  {31'd0, dmem_req}, 32'd0);
    chk("ill_rdata", rdata, 32'h0000_BEEF);
    tick();

    // Timeout with no ack
    reqs = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 40 && !done; i++) begin
      if (dmem_req) reqs++;
      tick();
    end
    chk("tmo_reqs", reqs, 32'd16);
    chk("tmo_done", {31'd0, done}, 32'd1);
    chk("tmo_code", {30'd0, err_code}, 32'd3);
    chk("tmo_err",  {31'd0, err}, 32'd1);
    tick();

    // Ack on exactly REQ cycle 16
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("ack16_req", {31'd0, dmem_req}, 32'd1);
    dmem_rdata = 32'hCAFE_BABE;
    dmem_ack   = 1'b1;
    tick();
    dmem_ack   = 1'b0;
    chk("ack16_done",  {31'd0, done}, 32'd1);
    chk("ack16_err",   {29'd0, err, err_code}, 32'd0);
    chk("ack16_rdata", rdata, 32'hCAFE_BABE);
    tick();

    // Reset during REQ cycle 2
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'd0);
    tick();
    chk("rr_req_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rr_req",   {31'd0, dmem_req}, 32'd0);
    chk("rr_state", {30'd0, busy, done}, 32'd0);
    chk("rr_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    // start right after reset: lbu addr 0x101
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'd0);
    chk("ar_req", {31'd0, dmem_req}, 32'd1);
    dmem_rdata = 32'h0000_9900;
    dmem_ack   = 1'b1;
    tick();
    dmem_ack   = 1'b0;
    chk("ar_done",  {31'd0, done}, 32'd1);
    chk("ar_rdata", rdata, 32'h0000_0099);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
